// File: rtl/cmp_sort_pkg.sv
// Shared types and constants for the comparator-scheduled batch sorter.
package cmp_sort_pkg;

    localparam int unsigned W = 4;
    localparam logic [7:0] SWAP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        SORT  = 2'b01,
        DRAIN = 2'b10
    } state_e;

    // Saturating increment for the swap counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SWAP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/FourBitComparator.sv
// Unsigned 4-bit magnitude comparator with cascade inputs used when A == B.
module FourBitComparator (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       lt_in,
    input  logic       eq_in,
    input  logic       gt_in,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        gt = 1'b0;
        if (A > B) begin
            gt = 1'b1;
        end else if (A < B) begin
            lt = 1'b1;
        end else begin
            lt = lt_in;
            eq = eq_in;
            gt = gt_in;
        end
    end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Batch bubble sorter: loads N words, sorts them with one shared comparator
// (one compare per cycle, early exit), then streams them out.
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned DESCEND = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic [7:0]   swap_count
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] PASS_MAX = IW'(N - 2);

    state_e         state_q, state_d;
    logic [IW-1:0]  wr_idx_q, wr_idx_d;
    logic [IW-1:0]  rd_idx_q, rd_idx_d;
    logic [IW-1:0]  i_q, i_d;
    logic [IW-1:0]  pass_q, pass_d;
    logic           swapped_q, swapped_d;
    logic [7:0]     swap_count_q, swap_count_d;
    logic [W-1:0]   mem_q [N];
    logic [W-1:0]   mem_d [N];

    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   out_data_q, out_data_d;

    logic [IW-1:0]  idx_nxt;
    logic [W-1:0]   cmp_a, cmp_b;
    logic           cmp_lt, cmp_eq, cmp_gt;
    logic           do_swap, pass_last;

    assign idx_nxt = i_q + IW'(1);
    assign cmp_a   = mem_q[i_q];
    assign cmp_b   = mem_q[idx_nxt];

    // Cascade tied to "equal" so A == B reports eq only.
    FourBitComparator u_cmp (
        .A     (cmp_a),
        .B     (cmp_b),
        .lt_in (1'b0),
        .eq_in (1'b1),
        .gt_in (1'b0),
        .lt    (cmp_lt),
        .eq    (cmp_eq),
        .gt    (cmp_gt)
    );

    // Equal pairs never swap, which keeps the sort stable.
    assign do_swap   = (state_q == SORT) && !cmp_eq && ((DESCEND != 0) ? cmp_lt : cmp_gt);
    assign pass_last = (i_q == (PASS_MAX - pass_q));

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        i_d          = i_q;
        pass_d       = pass_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;
        mem_d        = mem_q;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == '0) begin
                        swap_count_d = 8'd0;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d  = '0;
                        i_d       = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                        state_d   = SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            SORT: begin
                if (do_swap) begin
                    mem_d[i_q]     = cmp_b;
                    mem_d[idx_nxt] = cmp_a;
                    swap_count_d   = sat_inc(swap_count_q);
                end
                if (pass_last) begin
                    if (!(swapped_q || do_swap) || (pass_q == PASS_MAX)) begin
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        pass_d    = pass_q + IW'(1);
                        i_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    i_d       = idx_nxt;
                    swapped_d = swapped_q | do_swap;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Handshake outputs are registered from the next state.
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != LOAD);
        out_last_d  = (state_d == DRAIN) && (rd_idx_d == LAST_IDX);
        out_data_d  = mem_d[rd_idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            i_q          <= '0;
            pass_q       <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= 8'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            i_q          <= i_d;
            pass_q       <= pass_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            out_data_q   <= out_data_d;
        end
    end

    // Register file contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign out_data   = out_data_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Bench for cmp_sort_ctrl: ascending and descending instances checked against
// a counting-sort / inversion-count reference model.
module tb_cmp_sort_ctrl;

    localparam int N = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       in_valid  [2];
    logic [3:0] in_data   [2];
    logic       out_ready [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic [3:0] out_data  [2];
    logic       out_last  [2];
    logic       busy      [2];
    logic [7:0] swap_count[2];

    cmp_sort_ctrl #(.N(N), .DESCEND(0)) dut_asc (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]),
        .swap_count(swap_count[0])
    );

    cmp_sort_ctrl #(.N(N), .DESCEND(1)) dut_desc (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]),
        .swap_count(swap_count[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cur     [N];
    int exp_out [N];
    int exp_swaps;
    int exp_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output order by value bucket; swaps = inversion count; passes from the
    // largest number of out-of-order elements ahead of any single element.
    function automatic void build_model(input int desc);
        int idx = 0;
        int swaps = 0;
        int m = 0;
        int passes;
        for (int s = 0; s < 16; s++) begin
            int v = (desc != 0) ? 15 - s : s;
            for (int k = 0; k < N; k++) begin
                if (cur[k] == v) begin
                    exp_out[idx] = v;
                    idx++;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            int left = 0;
            for (int i = 0; i < j; i++) begin
                if ((desc != 0) ? (cur[i] < cur[j]) : (cur[i] > cur[j])) left++;
            end
            swaps += left;
            if (left > m) m = left;
        end
        passes = (m + 1 < N - 1) ? m + 1 : N - 1;
        exp_cycles = 0;
        for (int p = 0; p < passes; p++) exp_cycles += N - 1 - p;
        exp_swaps = (swaps > 255) ? 255 : swaps;
    endfunction

    task automatic set_seq(input int start, input int stepv);
        for (int k = 0; k < N; k++) cur[k] = start + stepv * k;
    endtask

    task automatic load_words(input int d);
        for (int k = 0; k < N; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid[d] = 1'b0;
                in_data[d]  = 4'($urandom);
            end
            @(negedge clk);
            check($sformatf("in_ready_load[%0d]", d), 32'(in_ready[d]), 32'd1);
            in_valid[d] = 1'b1;
            in_data[d]  = 4'(cur[k]);
            @(posedge clk);
        end
    endtask

    task automatic sort_phase(input int d, input int abort_at, output int cycles);
        logic saw_bad = 1'b0;
        logic aborted = 1'b0;
        cycles = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (out_valid[d] === 1'b1) break;
            cycles++;
            if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) saw_bad = 1'b1;
            if (abort_at == cycles) begin
                rst[d]  = 1'b1;
                aborted = 1'b1;
                break;
            end
            in_valid[d] = 1'($urandom_range(0, 1));
            in_data[d]  = 4'($urandom);
        end
        in_valid[d] = 1'b0;
        check($sformatf("sort_flags[%0d]", d), 32'(saw_bad), 32'd0);
        if (!aborted) check($sformatf("sort_done[%0d]", d), 32'(out_valid[d]), 32'd1);
    endtask

    task automatic drain(input int d, input int mode);
        int k = 0;
        int step = 0;
        logic rdy;
        while (k < N && step < 400) begin
            check($sformatf("out_valid[%0d]", d), 32'(out_valid[d]), 32'd1);
            check($sformatf("out_data[%0d][%0d]", d, k), 32'(out_data[d]), 32'(exp_out[k]));
            check($sformatf("out_last[%0d][%0d]", d, k), 32'(out_last[d]), 32'(k == N - 1));
            check($sformatf("busy_drain[%0d]", d), 32'(busy[d]), 32'd1);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ((step % 3) == 0);
            else                rdy = 1'($urandom_range(0, 1));
            step++;
            out_ready[d] = rdy;
            @(posedge clk);
            if (rdy) k++;
            @(negedge clk);
        end
        out_ready[d] = 1'b0;
        check($sformatf("handshakes[%0d]", d), 32'(k), 32'(N));
        check($sformatf("in_ready_after[%0d]", d), 32'(in_ready[d]), 32'd1);
        check($sformatf("out_valid_after[%0d]", d), 32'(out_valid[d]), 32'd0);
        check($sformatf("busy_after[%0d]", d), 32'(busy[d]), 32'd0);
        check($sformatf("swap_count[%0d]", d), 32'(swap_count[d]), 32'(exp_swaps));
    endtask

    task automatic run_batch(input int d, input int mode);
        int cyc;
        build_model(d);
        load_words(d);
        sort_phase(d, 0, cyc);
        check($sformatf("sort_cycles[%0d]", d), 32'(cyc), 32'(exp_cycles));
        drain(d, mode);
    endtask

    task automatic check_idle(input int d, input string tag);
        check($sformatf("%s_in_ready[%0d]", tag, d), 32'(in_ready[d]), 32'd1);
        check($sformatf("%s_out_valid[%0d]", tag, d), 32'(out_valid[d]), 32'd0);
        check($sformatf("%s_out_last[%0d]", tag, d), 32'(out_last[d]), 32'd0);
        check($sformatf("%s_busy[%0d]", tag, d), 32'(busy[d]), 32'd0);
        check($sformatf("%s_swaps[%0d]", tag, d), 32'(swap_count[d]), 32'd0);
    endtask

    initial begin
        int cyc;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = 4'd0; out_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            rst[d] = 1'b0;
        end

        for (int d = 0; d < 2; d++) begin
            set_seq(0, 1);
            run_batch(d, 0);
            set_seq(15, -1);
            run_batch(d, 0);
            cur = '{5, 3, 5, 3, 9, 0, 9, 0};
            run_batch(d, 0);
            for (int k = 0; k < N; k++) cur[k] = int'($urandom_range(0, 15));
            run_batch(d, 1);

            set_seq(15, -1);
            load_words(d);
            sort_phase(d, 3, cyc);
            @(posedge clk);
            @(negedge clk);
            check_idle(d, "abort");
            rst[d] = 1'b0;
            set_seq(7, -1);
            run_batch(d, 0);

            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < N; k++) cur[k] = int'($urandom_range(0, 15));
                run_batch(d, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
